// File: rtl/orxor_serial_seq_if.sv
// Request/result bundle for the bit-serial OR/XOR/ADD sequencer.
// in_valid/in_ready and out_valid/out_ready are strict valid/ready pairs: a transfer happens on the rising edge where both are high, and valid is held until it does.
interface orxor_serial_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic             carry;
   logic             busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, q, carry, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, q, carry, busy
   );
endinterface

// File: rtl/orxor_serial_seq.sv
// Bit-serial logic/arith unit: one shared 1-bit OR/XOR cell walks the operands LSB first.
// ADD reuses the XOR cell with a carry flip-flop and majority logic.
module orxor_serial_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   orxor_serial_seq_if.slave   bus,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;

   state_t           r_state;
   state_t           w_next;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_busy;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [1:0]       r_sop;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cy;
   logic [WIDTH-1:0] r_q;
   logic             r_carry;

   logic             w_a0;
   logic             w_b0;
   logic             w_sel;
   logic             w_x;
   logic             w_r;
   logic             w_cy_next;
   logic [WIDTH-1:0] w_res_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = ST_RUN;
         end
         ST_RUN: begin
            w_busy = 1'b1;
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            w_busy      = 1'b1;
            w_out_valid = 1'b1;
            if (bus.out_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_accept = bus.in_valid && w_in_ready;
   assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

   // The shared cell: select picks XOR for both XOR and ADD.
   assign w_a0  = r_sa[0];
   assign w_b0  = r_sb[0];
   assign w_sel = (r_sop == OP_XOR) || (r_sop == OP_ADD);
   assign w_x   = w_sel ? (w_a0 ^ w_b0) : (w_a0 | w_b0);

   always_comb begin
      w_r       = 1'b0;
      w_cy_next = 1'b0;
      case (r_sop)
         OP_OR:   w_r = w_x;
         OP_XOR:  w_r = w_x;
         OP_ADD: begin
            w_r       = w_x ^ r_cy;
            w_cy_next = (w_a0 & w_b0) | (r_cy & w_x);
         end
         default: begin
            w_r       = 1'b0;
            w_cy_next = 1'b0;
         end
      endcase
   end

   assign w_res_next = {w_r, r_res[WIDTH-1:1]};

   // q/carry are only written on the final RUN edge so they never show partial results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_res   <= '0;
         r_sop   <= '0;
         r_cnt   <= '0;
         r_cy    <= 1'b0;
         r_q     <= '0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_sa  <= bus.a;
         r_sb  <= bus.b;
         r_sop <= bus.op;
         r_res <= '0;
         r_cnt <= '0;
         r_cy  <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
         r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
         r_res <= w_res_next;
         r_cnt <= r_cnt + CNT_W'(1);
         r_cy  <= w_cy_next;
         if (w_last) begin
            r_q     <= w_res_next;
            r_carry <= (r_sop == OP_ADD) ? w_cy_next : 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.q         = r_q;
   assign bus.carry     = r_carry;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_orxor_serial_seq.sv
// Directed bench for orxor_serial_seq: vector table plus reset/backpressure/reserved-op sequences.
module tb_orxor_serial_seq;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   typedef struct {
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_q;
      logic             exp_c;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_checks = 0;
   int         n_errors = 0;
   vec_t       vecs[9];

   orxor_serial_seq_if #(.WIDTH(WIDTH)) bus ();

   orxor_serial_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at the negedge after an accept; returns edges until out_valid is seen.
   task automatic wait_done(input string name, output int edges, output bit ok);
      logic [WIDTH-1:0] q_hold;
      logic             c_hold;
      bit               stable;
      q_hold = bus.q;
      c_hold = bus.carry;
      stable = 1'b1;
      edges  = 0;
      ok     = 1'b0;
      while (!ok && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus.out_valid) ok = 1'b1;
         else if (bus.q !== q_hold || bus.carry !== c_hold) stable = 1'b0;
      end
      check({name, " q_stable_during_run"}, 32'(stable), 32'd1);
      check({name, " done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_q, input logic exp_c);
      int edges;
      bit ok;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      check({name, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({name, " busy_after_accept"}, 32'(bus.busy), 32'd1);
      wait_done(name, edges, ok);
      check({name, " latency"}, 32'(edges), 32'(WIDTH));
      check({name, " q"}, 32'(bus.q), 32'(exp_q));
      check({name, " carry"}, 32'(bus.carry), 32'(exp_c));
      @(posedge clk);
      @(negedge clk);
      check({name, " out_valid_one_cycle"}, 32'(bus.out_valid), 32'd0);
      check({name, " in_ready_after_hs"}, 32'(bus.in_ready), 32'd1);
      check({name, " q_held_after_hs"}, 32'(bus.q), 32'(exp_q));
   endtask

   initial begin
      int  edges;
      bit  ok;
      bit  ov_seen;

      vecs[0] = '{2'b00, 8'hA5, 8'h0F, 8'hAF, 1'b0};
      vecs[1] = '{2'b01, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      vecs[2] = '{2'b10, 8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[3] = '{2'b10, 8'h3C, 8'h15, 8'h51, 1'b0};
      vecs[4] = '{2'b01, 8'hAA, 8'h55, 8'hFF, 1'b0};
      vecs[5] = '{2'b10, 8'h80, 8'h80, 8'h00, 1'b1};
      vecs[6] = '{2'b00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[7] = '{2'b10, 8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[8] = '{2'b10, 8'hFF, 8'hFF, 8'hFE, 1'b1};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset q", 32'(bus.q), 32'd0);
      check("reset carry", 32'(bus.carry), 32'd0);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_c);
      end

      // Reset three cycles into an OR; q currently holds 0xFE from the last vector.
      bus.op        = 2'b00;
      bus.a         = 8'h5A;
      bus.b         = 8'h0F;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      ov_seen      = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid) ov_seen = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst q", 32'(bus.q), 32'd0);
      check("midrst carry", 32'(bus.carry), 32'd0);
      check("midrst busy", 32'(bus.busy), 32'd0);
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid) ov_seen = 1'b1;
      end
      check("midrst out_valid_never", 32'(ov_seen), 32'd0);
      run_op("after_rst", 2'b00, 8'h5A, 8'h0F, 8'h5F, 1'b0);

      // Backpressure on XOR with the next request (ADD 0xFF+0x02) held on the input.
      bus.op        = 2'b01;
      bus.a         = 8'h33;
      bus.b         = 8'h55;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.op = 2'b10;
      bus.a  = 8'hFF;
      bus.b  = 8'h02;
      check("bp in_ready_run", 32'(bus.in_ready), 32'd0);
      wait_done("bp_xor", edges, ok);
      check("bp_xor latency", 32'(edges), 32'(WIDTH));
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp stall%0d q", k), 32'(bus.q), 32'h66);
         check($sformatf("bp stall%0d carry", k), 32'(bus.carry), 32'd0);
         check($sformatf("bp stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
         check($sformatf("bp stall%0d out_valid", k), 32'(bus.out_valid), 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp hs out_valid", 32'(bus.out_valid), 32'd0);
      check("bp hs in_ready", 32'(bus.in_ready), 32'd1);
      check("bp hs busy", 32'(bus.busy), 32'd0);
      check("bp hs q", 32'(bus.q), 32'h66);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp reaccept busy", 32'(bus.busy), 32'd1);
      check("bp reaccept in_ready", 32'(bus.in_ready), 32'd0);
      wait_done("bp_add", edges, ok);
      check("bp_add latency", 32'(edges), 32'(WIDTH));
      check("bp_add q", 32'(bus.q), 32'h01);
      check("bp_add carry", 32'(bus.carry), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("bp_add out_valid_one_cycle", 32'(bus.out_valid), 32'd0);

      run_op("reserved", 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
